// File: rtl/imem_loader_if.sv
// Loader-side bundle: byte stream in (valid/ready) and the CPU fetch port.
// The loader is the slave on both; the stream source / CPU side is the master.
interface imem_loader_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_data;

  modport master (
    output s_valid, s_data, fetch_addr,
    input  s_ready, fetch_data
  );

  modport slave (
    input  s_valid, s_data, fetch_addr,
    output s_ready, fetch_data
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory with a checksummed byte-stream loader that holds the CPU in reset until a good image is in.
// Fetch reads are combinational; s_ready depends on state only (LEN/DATA/SUM), never on s_valid.
module imem_loader #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_req_i,
  imem_loader_if.slave  bus,
  output logic          cpu_rst_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW:0]   count_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LEN  = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] SUM  = 3'd3;
  localparam logic [2:0] FILL = 3'd4;
  localparam logic [2:0] RUN  = 3'd5;
  localparam logic [2:0] ERR  = 3'd6;

  localparam logic [DW-1:0] DEPTH_D = DW'(2**AW);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(2**AW);
  localparam logic [AW:0]   LAST_C  = (AW+1)'(2**AW - 1);
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);

  logic [2:0]    state, state_nxt;
  logic [AW:0]   count, count_nxt;
  logic [AW:0]   len, len_nxt;
  logic [DW-1:0] sum, sum_nxt;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          xfer;

  logic [DW-1:0] mem [0:2**AW-1];

  assign bus.s_ready = (state == LEN) || (state == DATA) || (state == SUM);
  assign xfer        = bus.s_valid && bus.s_ready;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    len_nxt   = len;
    sum_nxt   = sum;
    wr_en     = 1'b0;
    wr_data   = bus.s_data;
    case (state)
      IDLE, RUN, ERR: begin
        if (load_req_i) state_nxt = LEN;
      end
      LEN: begin
        if (xfer) begin
          len_nxt   = bus.s_data[AW:0];
          count_nxt = '0;
          sum_nxt   = '0;
          if (bus.s_data == '0 || bus.s_data > DEPTH_D) state_nxt = ERR;
          else                                           state_nxt = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          wr_en     = 1'b1;
          sum_nxt   = sum + bus.s_data;
          count_nxt = count + ONE_C;
          if (count_nxt == len) state_nxt = SUM;
        end
      end
      SUM: begin
        if (xfer) begin
          if ((sum + bus.s_data) == '0) state_nxt = FILL;
          else                          state_nxt = ERR;
        end
      end
      FILL: begin
        // A full-length image arrives here with count already at depth: one idle cycle, no write.
        if (count == DEPTH_C) begin
          state_nxt = RUN;
        end else begin
          wr_en     = 1'b1;
          wr_data   = '0;
          count_nxt = count + ONE_C;
          if (count == LAST_C) state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      count <= '0;
      len   <= '0;
      sum   <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      len   <= len_nxt;
      sum   <= sum_nxt;
    end
  end

  // Memory survives reset; a reset edge only suppresses the write.
  always_ff @(posedge clk_i) begin
    if (wr_en && rst_i) mem[count[AW-1:0]] <= wr_data;
  end

  assign bus.fetch_data = mem[bus.fetch_addr];

  assign cpu_rst_o = (state != RUN);
  assign busy_o    = (state == LEN) || (state == DATA) || (state == SUM) || (state == FILL);
  assign done_o    = (state == RUN);
  assign err_o     = (state == ERR);
  assign count_o   = count;

endmodule
